// File: rtl/usb_pkg.sv
// Shared USB package: buffer geometry defaults and the occupancy width helper.
package usb_pkg;

    localparam int USB_BUF_DEPTH = 64;
    localparam int USB_BUF_WIDTH = 8;

    // Occupancy spans 0..depth inclusive, so it needs one bit more than the index.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int USB_BUF_OCC_W = occ_width(USB_BUF_DEPTH);

endpackage

// File: rtl/usb_buffer_ptr.sv
// FIFO pointer register: increments on enable, wraps modulo 2**PTR_W
// (index bits plus a wrap bit), synchronously cleared, async active-low reset.
module usb_buffer_ptr
    import usb_pkg::*;
#(
    parameter int PTR_W = USB_BUF_OCC_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear dominates, otherwise step by one with natural wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared USB data buffer: one circular FIFO written from either the USB RX
// side or the host side, read by either the host side or the USB TX side.
// RX writes beat host writes, TX reads beat host reads; clear beats all.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = USB_BUF_DEPTH,
    parameter int WIDTH = USB_BUF_WIDTH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       store_rx_packet_data,
    input  logic [WIDTH-1:0]           rx_packet_data,
    input  logic                       store_tx_data,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       get_rx_data,
    output logic [WIDTH-1:0]           rx_data,
    input  logic                       get_tx_packet_data,
    output logic [WIDTH-1:0]           tx_packet_data,
    output logic [occ_width(DEPTH)-1:0] buffer_occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] wptr;
    logic [OCC_W-1:0] rptr;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] rx_data_d;
    logic [WIDTH-1:0] tx_pkt_q;
    logic [WIDTH-1:0] tx_pkt_d;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] head;
    logic             wr_req;
    logic             rd_req;
    logic             wr_acc;
    logic             rd_acc;

    assign empty  = (occ_q == '0);
    assign full   = (occ_q == OCC_W'(DEPTH));
    assign wr_req = store_rx_packet_data | store_tx_data;
    assign rd_req = get_tx_packet_data | get_rx_data;
    // A read needs data already stored; a write into a full buffer only
    // fits when a read frees a slot on the same edge.
    assign rd_acc = !clear && rd_req && !empty;
    assign wr_acc = !clear && wr_req && (!full || rd_acc);
    assign wdata  = store_rx_packet_data ? rx_packet_data : tx_data;
    assign head   = mem_q[rptr[AW-1:0]];

    usb_buffer_ptr #(.PTR_W(OCC_W)) u_wptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (clear),
        .en_i    (wr_acc),
        .ptr_o   (wptr)
    );

    usb_buffer_ptr #(.PTR_W(OCC_W)) u_rptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (clear),
        .en_i    (rd_acc),
        .ptr_o   (rptr)
    );

    // Storage write: plain flops, contents are meaningless outside [rptr, wptr).
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr[AW-1:0]] <= wdata;
        end
    end

    // Next occupancy and output data: the winning read side loads the head.
    always_comb begin
        occ_d     = occ_q + OCC_W'(wr_acc) - OCC_W'(rd_acc);
        rx_data_d = rx_data_q;
        tx_pkt_d  = tx_pkt_q;
        if (clear) begin
            occ_d     = '0;
            rx_data_d = '0;
            tx_pkt_d  = '0;
        end else if (rd_acc) begin
            if (get_tx_packet_data) begin
                tx_pkt_d = head;
            end else begin
                rx_data_d = head;
            end
        end
    end

    // Occupancy and read-data registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            occ_q     <= '0;
            rx_data_q <= '0;
            tx_pkt_q  <= '0;
        end else begin
            occ_q     <= occ_d;
            rx_data_q <= rx_data_d;
            tx_pkt_q  <= tx_pkt_d;
        end
    end

    assign buffer_occupancy = occ_q;
    assign rx_data          = rx_data_q;
    assign tx_packet_data   = tx_pkt_q;

endmodule
